// File: rtl/mem_port_ctrl.sv
// Port B sequencer/arbiter: one FSM transaction per request, RMW for partial stores.
// Latency to done: 2 (full/MMIO/loader write), RD_LAT+1 (load), RD_LAT+2 (partial store).
// Backpressure: requester holds req until its done pulse; the loser of arbitration simply waits.
module mem_port_ctrl #(
    parameter int          RD_LAT = 2,
    parameter logic [15:0] IO_HI  = 16'hffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    input  logic        ldr_req,
    input  logic [31:0] ldr_addr,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        own_ldr;
    logic        last_ldr;
    logic        txn_we;
    logic [3:0]  txn_be;
    logic [31:0] txn_wdata;

    logic        grant_ldr;
    logic        cpu_mmio;
    logic        go_write;
    logic [31:0] req_addr;
    logic [31:0] merged;
    logic        unused_ldr_lsb;

    assign unused_ldr_lsb = ^ldr_addr[1:0];

    always_comb begin
        // On a tie the loader wins unless it was the last one served.
        grant_ldr = ldr_req && (!cpu_req || !last_ldr);
        cpu_mmio  = (cpu_addr[31:16] == IO_HI);
        go_write  = grant_ldr || (cpu_we && (cpu_be == 4'hF || cpu_mmio));
        if (grant_ldr)
            req_addr = {ldr_addr[31:2], 2'b00};
        else if (cpu_mmio)
            req_addr = cpu_addr;
        else
            req_addr = {cpu_addr[31:2], 2'b00};
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (txn_be[i])
                merged[8*i +: 8] = txn_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            own_ldr   <= 1'b0;
            last_ldr  <= 1'b0;
            txn_we    <= 1'b0;
            txn_be    <= 4'h0;
            txn_wdata <= 32'h0;
            cpu_rdata <= 32'h0;
            cpu_done  <= 1'b0;
            ldr_done  <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            cpu_done <= 1'b0;
            ldr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ldr_req || cpu_req) begin
                        own_ldr   <= grant_ldr;
                        txn_we    <= grant_ldr || cpu_we;
                        txn_be    <= grant_ldr ? 4'hF : cpu_be;
                        txn_wdata <= grant_ldr ? ldr_wdata : cpu_wdata;
                        mem_addr  <= req_addr;
                        busy      <= 1'b1;
                        if (go_write) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= grant_ldr ? ldr_wdata : cpu_wdata;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= 2'(RD_LAT - 1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 2'd0) begin
                        if (!txn_we) begin
                            cpu_rdata <= mem_rdata;
                            cpu_done  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_wdata <= merged;
                            state     <= WRITE;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                WRITE: begin
                    cpu_done <= !own_ldr;
                    ldr_done <= own_ldr;
                    state    <= DONE;
                end
                DONE: begin
                    last_ldr <= own_ldr;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
